mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port 512x32 program/data RAM between two requesters:
  - port 0: the CPU datapath (MAR/MDR side, driven by the control unit);
  - port 1: a loader/debug port that preloads programs and inspects memory while the CPU is stalled or running.
- Sits between the datapath/control unit and the RAM instance in the system top.
- Serialises one transaction at a time through a small FSM.
- Arbitrates round-robin or with fixed CPU priority, and returns read data with a single-cycle ack pulse.

Parameters:
- ADDR_W, 9, RAM address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the RAM capturing rden/address until q is valid. Legal range 1..4.
- ROUND_ROBIN, 1, 1 = alternate on contention; 0 = port 0 (CPU) always wins.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- in_cpu_req  in  1  CPU transaction request; level, held until ack.
- in_cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- in_cpu_addr  in  ADDR_W  CPU address; sampled at grant.
- in_cpu_wdata  in  DATA_W  CPU write data; sampled at grant.
- out_cpu_ack  out  1  one-cycle completion pulse.
- out_cpu_rdata  out  DATA_W  read data; valid in the ack cycle and held until the next CPU read completes.
- in_dbg_req, in_dbg_we, in_dbg_addr, in_dbg_wdata, out_dbg_ack, out_dbg_rdata: same as the CPU set, for port 1.
- out_mem_address  out  ADDR_W  RAM address, registered.
- out_mem_data  out  DATA_W  RAM write data, registered.
- out_mem_rden  out  1  RAM read enable, registered.
- out_mem_wren  out  1  RAM write enable, registered.
- in_mem_q  in  DATA_W  RAM read data.
- out_busy  out  1  high in any state other than IDLE.
- out_grant  out  1  id of the current or last granted port (0 = CPU, 1 = dbg).

Behaviour:
- Reset (reset == 0 at a rising edge):
  - state = IDLE; all acks, mem strobes and out_busy = 0; out_mem_address/out_mem_data = 0;
  - both rdata registers = 0; last_grant = 1, so the CPU wins the first tie; out_grant = 0.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. A write whose ISSUE cycle already completed may have landed in RAM; that is acceptable.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: with ROUND_ROBIN = 1, grant the port != last_grant; with ROUND_ROBIN = 0, grant port 0.
  - On grant: latch we/addr/wdata and the winner id, update last_grant, go to ISSUE.
- ISSUE (1 cycle): out_mem_address/out_mem_data = latched values; out_mem_wren = we; out_mem_rden = !we.
  - Write: go to DONE.
  - Read: go to WAIT with wait counter = MEM_LATENCY.
- WAIT: mem strobes low; counter decrements each cycle. In the cycle the counter == 1, sample in_mem_q into the winner's rdata register and go to DONE.
- DONE (1 cycle): the winner's ack = 1; go to IDLE.
- Latency from the req-sampled edge to ack high:
  - write = 2 cycles;
  - read = 2 + MEM_LATENCY cycles (3 with the default).
- Minimum spacing between grants is 3 cycles for a write and 3 + MEM_LATENCY cycles for a read, because IDLE always costs one cycle.
- Requester rule: req stays high until ack is seen.
  - A requester that keeps req high in the IDLE cycle after its ack is making a new transaction with its current we/addr/wdata.
  - Changes to we/addr/wdata after grant are ignored.
- A loser's req stays pending and is granted at the next IDLE.
  - Round-robin guarantees at most one foreign transaction before service.
  - With ROUND_ROBIN = 0, the debug port can starve; this is the intended behaviour.
- Acks are mutually exclusive; at most one mem strobe is high in any cycle.
- Non-winner rdata registers never change.
- Address and data pass through with no arithmetic; widths are exact and there is no address wrap logic.

Decomposition:
- Shared package (mem_arb_pkg):
  - FSM state encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  - port id constants: PORT_CPU = 0, PORT_DBG = 1;
  - latency counter width: 3 bits.
- Sub-module rr_pick2: combinational two-way grant from (req0, req1, last_grant, round_robin). It keeps the priority policy testable in isolation. The rest (FSM, latches, counter, rdata registers) lives in mem_arbiter.

Test Plan:
- Reset low for 2 cycles with both reqs high -> all acks, strobes and busy = 0, rdata = 0. After reset rises, the CPU is granted first (out_grant = 0).
- CPU write alone (addr 9'h010, wdata 32'hDEADBEEF) -> out_mem_wren high for exactly 1 cycle with those values; out_cpu_ack pulses 2 cycles after req is sampled.
- Debug read of 9'h010 after that write (MEM_LATENCY = 1) -> out_mem_rden for 1 cycle; out_dbg_ack at +3 cycles with out_dbg_rdata = 32'hDEADBEEF; out_cpu_rdata unchanged.
- Both reqs held continuously, ROUND_ROBIN = 1, 6 transactions -> grant order CPU, dbg, CPU, dbg, CPU, dbg; never two acks in one cycle.
- Same stimulus with ROUND_ROBIN = 0 -> all 6 transactions go to the CPU and out_dbg_ack never fires.
- Reset asserted during WAIT of a CPU read -> no ack, next state IDLE, strobes low, out_cpu_rdata = 0. A re-issued read completes normally with MEM_LATENCY = 3, acking at +5 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM encoding, port ids
// and the width of the read-latency counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/rr_pick2.sv
// Two-way grant decision: a lone requester always wins; on contention either
// alternate against the last grant or let port 0 win outright.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    input  logic round_robin,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = PORT_CPU;
        if (req0 && req1) begin
            grant_id = round_robin ? ~last_grant : PORT_CPU;
        end else if (req1) begin
            grant_id = PORT_DBG;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between the CPU (port 0) and a loader/debug
// port (port 1), one transaction at a time.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_cpu_req,
    input  logic              in_cpu_we,
    input  logic [ADDR_W-1:0] in_cpu_addr,
    input  logic [DATA_W-1:0] in_cpu_wdata,
    output logic              out_cpu_ack,
    output logic [DATA_W-1:0] out_cpu_rdata,
    input  logic              in_dbg_req,
    input  logic              in_dbg_we,
    input  logic [ADDR_W-1:0] in_dbg_addr,
    input  logic [DATA_W-1:0] in_dbg_wdata,
    output logic              out_dbg_ack,
    output logic [DATA_W-1:0] out_dbg_rdata,
    output logic [ADDR_W-1:0] out_mem_address,
    output logic [DATA_W-1:0] out_mem_data,
    output logic              out_mem_rden,
    output logic              out_mem_wren,
    input  logic [DATA_W-1:0] in_mem_q,
    output logic              out_busy,
    output logic              out_grant
);

    // Handshake: req is a level held until the one-cycle ack; we/addr/wdata
    // are captured only at the grant edge, and a req still high in the IDLE
    // cycle after ack starts a new transaction with the current request fields.

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LATENCY);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

    arb_state_t           state;
    arb_state_t           state_next;
    logic [LAT_CNT_W-1:0] wait_cnt;
    logic                 winner;
    logic                 last_grant;
    logic                 lat_we;
    logic                 pick_valid;
    logic                 pick_id;
    logic                 grant_fire;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;

    rr_pick2 u_pick (
        .req0        (in_cpu_req),
        .req1        (in_dbg_req),
        .last_grant  (last_grant),
        .round_robin (ROUND_ROBIN != 0),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    assign grant_fire = (state == IDLE) && pick_valid;
    assign sel_we     = pick_id ? in_dbg_we    : in_cpu_we;
    assign sel_addr   = pick_id ? in_dbg_addr  : in_cpu_addr;
    assign sel_wdata  = pick_id ? in_dbg_wdata : in_cpu_wdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   state_next = lat_we ? DONE : WAIT;
            WAIT:    if (wait_cnt == CNT_ONE) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The RAM strobes are loaded at the grant edge so they are high exactly
    // during ISSUE; address/data stay put until the next grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            winner          <= PORT_CPU;
            last_grant      <= PORT_DBG;
            lat_we          <= 1'b0;
            wait_cnt        <= '0;
            out_mem_address <= '0;
            out_mem_data    <= '0;
            out_mem_rden    <= 1'b0;
            out_mem_wren    <= 1'b0;
            out_cpu_rdata   <= '0;
            out_dbg_rdata   <= '0;
        end else begin
            out_mem_rden <= 1'b0;
            out_mem_wren <= 1'b0;
            if (grant_fire) begin
                winner          <= pick_id;
                last_grant      <= pick_id;
                lat_we          <= sel_we;
                out_mem_address <= sel_addr;
                out_mem_data    <= sel_wdata;
                out_mem_wren    <= sel_we;
                out_mem_rden    <= ~sel_we;
            end
            if (state == ISSUE) begin
                wait_cnt <= LAT_INIT;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - CNT_ONE;
            end
            if ((state == WAIT) && (wait_cnt == CNT_ONE)) begin
                if (winner == PORT_DBG) begin
                    out_dbg_rdata <= in_mem_q;
                end else begin
                    out_cpu_rdata <= in_mem_q;
                end
            end
        end
    end

    assign out_busy    = (state != IDLE);
    assign out_cpu_ack = (state == DONE) && (winner == PORT_CPU);
    assign out_dbg_ack = (state == DONE) && (winner == PORT_DBG);
    assign out_grant   = winner;

endmodule
